// File: rtl/tff_toggle_monitor_if.sv
// Signal bundle between a T flip-flop toggle monitor and its consumer.
// master drives the control and the raw level; slave is the monitor itself.
interface tff_toggle_monitor_if #(
   parameter int unsigned CNT_W = 8,
   parameter int unsigned INT_W = 8
);
   logic             clear;
   logic             en;
   logic             data_in;
   logic             q_sync;
   logic             rise;
   logic             fall;
   logic [CNT_W-1:0] edge_cnt;
   logic [INT_W-1:0] interval;
   logic             interval_vld;
   logic             stall;

   modport master (
      output clear, en, data_in,
      input  q_sync, rise, fall, edge_cnt, interval, interval_vld, stall
   );

   modport slave (
      input  clear, en, data_in,
      output q_sync, rise, fall, edge_cnt, interval, interval_vld, stall
   );
endinterface

// File: rtl/tff_toggle_monitor.sv
// Synchronizes a toggling T flip-flop output, emits rise/fall pulses, counts edges,
// measures the cycle gap between consecutive edges and flags a stall when toggling stops.
module tff_toggle_monitor #(
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned INT_W   = 8,
   parameter int unsigned TIMEOUT = 32
) (
   input logic                 clk,
   input logic                 reset,
   tff_toggle_monitor_if.slave mon
);

   localparam int unsigned      GAP_W     = INT_W + 1;
   localparam logic [GAP_W-1:0] TIMEOUT_V = GAP_W'(TIMEOUT);

   typedef enum logic {
      ST_WAIT_FIRST,
      ST_MEASURE
   } state_t;

   state_t state, state_nxt;

   logic             sync1, sync2, prev;
   logic             edge_det;

   logic             rise_q, rise_nxt;
   logic             fall_q, fall_nxt;
   logic             ivld_q, ivld_nxt;
   logic             stall_q, stall_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic [INT_W-1:0] interval_q, interval_nxt;
   logic [INT_W-1:0] gap_cnt, gap_nxt;

   logic [GAP_W-1:0] gap_inc;
   logic [INT_W-1:0] gap_sat;

   // Synchronizer and previous-value flop run unconditionally so clear/en never
   // leave a stale level behind that would later look like an edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync1 <= mon.data_in;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign edge_det = sync2 ^ prev;

   assign gap_inc = {1'b0, gap_cnt} + GAP_W'(1);
   assign gap_sat = gap_inc[INT_W] ? '1 : gap_inc[INT_W-1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_WAIT_FIRST;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
         ivld_q     <= 1'b0;
         stall_q    <= 1'b0;
         cnt_q      <= '0;
         interval_q <= '0;
         gap_cnt    <= '0;
      end else begin
         state      <= state_nxt;
         rise_q     <= rise_nxt;
         fall_q     <= fall_nxt;
         ivld_q     <= ivld_nxt;
         stall_q    <= stall_nxt;
         cnt_q      <= cnt_nxt;
         interval_q <= interval_nxt;
         gap_cnt    <= gap_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      rise_nxt     = 1'b0;
      fall_nxt     = 1'b0;
      ivld_nxt     = 1'b0;
      stall_nxt    = stall_q;
      cnt_nxt      = cnt_q;
      interval_nxt = interval_q;
      gap_nxt      = gap_cnt;

      if (mon.clear) begin
         state_nxt    = ST_WAIT_FIRST;
         stall_nxt    = 1'b0;
         cnt_nxt      = '0;
         interval_nxt = '0;
         gap_nxt      = '0;
      end else if (mon.en) begin
         if (edge_det) begin
            rise_nxt  = sync2 & ~prev;
            fall_nxt  = ~sync2 & prev;
            cnt_nxt   = cnt_q + CNT_W'(1);
            // The first edge after reset/clear only arms the measurement.
            if (state == ST_MEASURE) begin
               interval_nxt = gap_sat;
               ivld_nxt     = 1'b1;
            end
            state_nxt = ST_MEASURE;
            gap_nxt   = '0;
            stall_nxt = 1'b0;
         end else begin
            gap_nxt = gap_sat;
            if (gap_inc >= TIMEOUT_V) begin
               stall_nxt = 1'b1;
            end
         end
      end
   end

   assign mon.q_sync       = sync2;
   assign mon.rise         = rise_q;
   assign mon.fall         = fall_q;
   assign mon.edge_cnt     = cnt_q;
   assign mon.interval     = interval_q;
   assign mon.interval_vld = ivld_q;
   assign mon.stall        = stall_q;

endmodule

// File: tb/tb_tff_toggle_monitor.sv
// Directed bench for tff_toggle_monitor: latency, interval measurement, stall,
// wrap, clear/enable interaction and asynchronous reset.
module tb_tff_toggle_monitor;

   localparam int unsigned CNT_W = 8;
   localparam int unsigned INT_W = 8;

   int tests = 0;
   int fails = 0;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   tff_toggle_monitor_if #(.CNT_W(CNT_W), .INT_W(INT_W)) bus ();

   tff_toggle_monitor #(
      .CNT_W  (CNT_W),
      .INT_W  (INT_W),
      .TIMEOUT(32)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .mon  (bus)
   );

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_clear();
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4; i++) begin
         bus.data_in = ~bus.data_in;
         @(negedge clk);
         tests++;
         if ({bus.q_sync, bus.rise, bus.fall, bus.edge_cnt, bus.interval,
              bus.interval_vld, bus.stall} !== '0) begin
            fails++;
            $display("FAIL reset_hold%0d: q_sync=%b rise=%b fall=%b edge_cnt=%0d interval=%0d vld=%b stall=%b, required all 0",
                     i, bus.q_sync, bus.rise, bus.fall, bus.edge_cnt, bus.interval,
                     bus.interval_vld, bus.stall);
         end
      end
   endtask

   task automatic test_first_edge();
      bus.data_in = 1'b0;
      reset = 1'b1;
      step(3);
      tests++;
      if ({bus.q_sync, bus.rise, bus.fall, bus.edge_cnt} !== '0) begin
         fails++;
         $display("FAIL first_idle: q_sync=%b rise=%b fall=%b edge_cnt=%0d, required 0",
                  bus.q_sync, bus.rise, bus.fall, bus.edge_cnt);
      end
      bus.data_in = 1'b1;
      step(1);
      tests++;
      if (bus.q_sync !== 1'b0) begin
         fails++;
         $display("FAIL first_qsync_n: q_sync=%b, required 0", bus.q_sync);
      end
      step(1);
      tests++;
      if (bus.q_sync !== 1'b1 || bus.rise !== 1'b0) begin
         fails++;
         $display("FAIL first_qsync_n1: q_sync=%b rise=%b, required q_sync=1 rise=0",
                  bus.q_sync, bus.rise);
      end
      step(1);
      tests++;
      if (bus.rise !== 1'b1 || bus.fall !== 1'b0 || bus.edge_cnt !== 8'd1 ||
          bus.interval_vld !== 1'b0) begin
         fails++;
         $display("FAIL first_pulse: rise=%b fall=%b edge_cnt=%0d vld=%b, required rise=1 fall=0 edge_cnt=1 vld=0",
                  bus.rise, bus.fall, bus.edge_cnt, bus.interval_vld);
      end
      step(1);
      tests++;
      if (bus.rise !== 1'b0) begin
         fails++;
         $display("FAIL first_single: rise=%b, required 0", bus.rise);
      end
   endtask

   task automatic test_periodic();
      int   vld_pulses = 0;
      logic stall_seen = 1'b0;
      logic exp_rise;
      pulse_clear();
      for (int i = 0; i < 6; i++) begin
         bus.data_in = ~bus.data_in;
         exp_rise    = bus.data_in;
         for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.interval_vld === 1'b1) vld_pulses++;
            if (bus.stall !== 1'b0) stall_seen = 1'b1;
            if (c == 3) begin
               tests++;
               if (bus.rise !== exp_rise || bus.fall !== ~exp_rise ||
                   bus.edge_cnt !== 8'(i + 1)) begin
                  fails++;
                  $display("FAIL periodic_edge%0d: rise=%b fall=%b edge_cnt=%0d, required rise=%b fall=%b edge_cnt=%0d",
                           i, bus.rise, bus.fall, bus.edge_cnt, exp_rise, ~exp_rise, i + 1);
               end
               if (i > 0) begin
                  tests++;
                  if (bus.interval !== 8'd10 || bus.interval_vld !== 1'b1) begin
                     fails++;
                     $display("FAIL periodic_interval%0d: interval=%0d vld=%b, required 10 vld=1",
                              i, bus.interval, bus.interval_vld);
                  end
               end
            end else if (c == 4) begin
               tests++;
               if (bus.rise !== 1'b0 || bus.fall !== 1'b0) begin
                  fails++;
                  $display("FAIL periodic_single%0d: rise=%b fall=%b, required 0 0",
                           i, bus.rise, bus.fall);
               end
            end
         end
      end
      tests++;
      if (vld_pulses != 5) begin
         fails++;
         $display("FAIL periodic_vld_count: got %0d pulses, required 5", vld_pulses);
      end
      tests++;
      if (stall_seen !== 1'b0) begin
         fails++;
         $display("FAIL periodic_stall: stall seen=%b, required 0", stall_seen);
      end
   endtask

   task automatic test_stall();
      bus.data_in = ~bus.data_in;
      step(3);
      tests++;
      if (bus.stall !== 1'b0 || (bus.rise | bus.fall) !== 1'b1) begin
         fails++;
         $display("FAIL stall_edge: stall=%b rise=%b fall=%b, required stall=0 with a pulse",
                  bus.stall, bus.rise, bus.fall);
      end
      step(31);
      tests++;
      if (bus.stall !== 1'b0) begin
         fails++;
         $display("FAIL stall_early31: stall=%b, required 0", bus.stall);
      end
      step(1);
      tests++;
      if (bus.stall !== 1'b1) begin
         fails++;
         $display("FAIL stall_at32: stall=%b, required 1", bus.stall);
      end
      step(265);
      bus.data_in = ~bus.data_in;
      step(2);
      tests++;
      if (bus.stall !== 1'b1 || bus.interval_vld !== 1'b0) begin
         fails++;
         $display("FAIL stall_held: stall=%b vld=%b, required stall=1 vld=0",
                  bus.stall, bus.interval_vld);
      end
      step(1);
      tests++;
      if (bus.stall !== 1'b0 || bus.interval !== 8'd255 || bus.interval_vld !== 1'b1) begin
         fails++;
         $display("FAIL stall_release: stall=%b interval=%0d vld=%b, required stall=0 interval=255 vld=1",
                  bus.stall, bus.interval, bus.interval_vld);
      end
      step(1);
   endtask

   task automatic test_wrap();
      pulse_clear();
      for (int i = 0; i < 256; i++) begin
         bus.data_in = ~bus.data_in;
         step(3);
         if (i == 254) begin
            tests++;
            if (bus.edge_cnt !== 8'd255) begin
               fails++;
               $display("FAIL wrap_pre: edge_cnt=%0d, required 255", bus.edge_cnt);
            end
         end else if (i == 255) begin
            tests++;
            if (bus.edge_cnt !== 8'd0 || bus.interval !== 8'd4 || bus.interval_vld !== 1'b1) begin
               fails++;
               $display("FAIL wrap_zero: edge_cnt=%0d interval=%0d vld=%b, required 0 4 1",
                        bus.edge_cnt, bus.interval, bus.interval_vld);
            end
         end
         step(1);
      end
   endtask

   task automatic test_clear_en();
      logic exp_rise;
      step(4);
      bus.data_in = ~bus.data_in;
      step(2);
      bus.clear = 1'b1;
      step(1);
      bus.clear = 1'b0;
      tests++;
      if (bus.edge_cnt !== 8'd0 || bus.rise !== 1'b0 || bus.fall !== 1'b0 ||
          bus.interval_vld !== 1'b0 || bus.interval !== 8'd0) begin
         fails++;
         $display("FAIL clear_on_edge: edge_cnt=%0d rise=%b fall=%b vld=%b interval=%0d, required all 0",
                  bus.edge_cnt, bus.rise, bus.fall, bus.interval_vld, bus.interval);
      end
      step(1);
      tests++;
      if (bus.edge_cnt !== 8'd0 || (bus.rise | bus.fall) !== 1'b0) begin
         fails++;
         $display("FAIL clear_no_spurious: edge_cnt=%0d rise=%b fall=%b, required 0",
                  bus.edge_cnt, bus.rise, bus.fall);
      end
      step(5);
      bus.data_in = ~bus.data_in;
      exp_rise    = bus.data_in;
      step(3);
      tests++;
      if (bus.edge_cnt !== 8'd1 || bus.interval_vld !== 1'b0 || bus.interval !== 8'd0 ||
          bus.rise !== exp_rise || bus.fall !== ~exp_rise) begin
         fails++;
         $display("FAIL clear_first_edge: edge_cnt=%0d vld=%b interval=%0d rise=%b fall=%b, required 1 0 0 %b %b",
                  bus.edge_cnt, bus.interval_vld, bus.interval, bus.rise, bus.fall,
                  exp_rise, ~exp_rise);
      end
      step(2);
      bus.en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.data_in = ~bus.data_in;
         for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests++;
            if ((bus.rise | bus.fall | bus.interval_vld) !== 1'b0) begin
               fails++;
               $display("FAIL en_off_pulse%0d_%0d: rise=%b fall=%b vld=%b, required 0",
                        i, c, bus.rise, bus.fall, bus.interval_vld);
            end
         end
      end
      tests++;
      if (bus.edge_cnt !== 8'd1 || bus.interval !== 8'd0) begin
         fails++;
         $display("FAIL en_off_hold: edge_cnt=%0d interval=%0d, required 1 0",
                  bus.edge_cnt, bus.interval);
      end
      bus.en = 1'b1;
      step(4);
      tests++;
      if (bus.edge_cnt !== 8'd1 || (bus.rise | bus.fall) !== 1'b0) begin
         fails++;
         $display("FAIL en_lost_edges: edge_cnt=%0d rise=%b fall=%b, required 1 0 0",
                  bus.edge_cnt, bus.rise, bus.fall);
      end
   endtask

   task automatic test_async_reset();
      pulse_clear();
      for (int i = 0; i < 42; i++) begin
         bus.data_in = ~bus.data_in;
         step(4);
      end
      step(40);
      tests++;
      if (bus.edge_cnt !== 8'h2A || bus.stall !== 1'b1) begin
         fails++;
         $display("FAIL async_setup: edge_cnt=%0h stall=%b, required 2a 1",
                  bus.edge_cnt, bus.stall);
      end
      bus.data_in = 1'b1;
      #2 reset = 1'b0;
      #1;
      tests++;
      if ({bus.q_sync, bus.rise, bus.fall, bus.edge_cnt, bus.interval,
           bus.interval_vld, bus.stall} !== '0) begin
         fails++;
         $display("FAIL async_clear: q_sync=%b rise=%b fall=%b edge_cnt=%0d interval=%0d vld=%b stall=%b, required all 0",
                  bus.q_sync, bus.rise, bus.fall, bus.edge_cnt, bus.interval,
                  bus.interval_vld, bus.stall);
      end
      step(3);
      reset = 1'b1;
      step(2);
      tests++;
      if (bus.q_sync !== 1'b1 || bus.rise !== 1'b0 || bus.edge_cnt !== 8'd0) begin
         fails++;
         $display("FAIL async_release_sync: q_sync=%b rise=%b edge_cnt=%0d, required 1 0 0",
                  bus.q_sync, bus.rise, bus.edge_cnt);
      end
      step(1);
      tests++;
      if (bus.rise !== 1'b1 || bus.edge_cnt !== 8'd1 || bus.interval_vld !== 1'b0 ||
          bus.stall !== 1'b0) begin
         fails++;
         $display("FAIL async_release_edge: rise=%b edge_cnt=%0d vld=%b stall=%b, required 1 1 0 0",
                  bus.rise, bus.edge_cnt, bus.interval_vld, bus.stall);
      end
      step(1);
      tests++;
      if (bus.rise !== 1'b0) begin
         fails++;
         $display("FAIL async_release_single: rise=%b, required 0", bus.rise);
      end
   endtask

   initial begin
      bus.clear   = 1'b0;
      bus.en      = 1'b1;
      bus.data_in = 1'b0;
      test_reset();
      test_first_edge();
      test_periodic();
      test_stall();
      test_wrap();
      test_clear_en();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/tff_toggle_monitor.md
Name: tff_toggle_monitor

Overview:
Downstream consumer of the T flip-flop output q. It synchronizes the toggling level into the local clock domain and emits single-cycle rise and fall pulses. It also counts edges, measures the cycle interval between consecutive edges, and flags a stall when the flop stops toggling. It feeds status and debug logic.

Parameters:
CNT_W, 8, width of the edge counter (wraps modulo 2^CNT_W).
INT_W, 8, width of the gap counter and the interval register (saturating).
TIMEOUT, 32, number of edge-free enabled cycles before stall asserts; legal range 1 to 2^INT_W-1.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset; all flops clear immediately while low.
clear  input  1  synchronous clear of the statistics.
en  input  1  count enable.
data_in  input  1  toggling level from the T flip-flop q.
q_sync  output  1  data_in after the 2-flop synchronizer.
rise  output  1  one-cycle pulse on a synchronized 0->1 edge.
fall  output  1  one-cycle pulse on a synchronized 1->0 edge.
edge_cnt  output  CNT_W  number of counted edges, both polarities.
interval  output  INT_W  cycles between the last two counted edges.
interval_vld  output  1  one-cycle pulse when interval is updated with a real measurement.
stall  output  1  level: no counted edge for at least TIMEOUT enabled cycles.

Behaviour:
- Reset (reset=0): sync1, sync2, prev, gap_cnt, edge_cnt, interval, all outputs = 0; first_seen = 0. Takes effect asynchronously; release is synchronous to clk.
- Synchronizer and edge detection:
  - Synchronizer: sync1<=data_in, sync2<=sync1, prev<=sync2. These run every cycle regardless of en and clear.
  - q_sync = sync2.
  - Internal edge_det = sync2 ^ prev.
- Latency: data_in change sampled at edge N:
  - q_sync updates after edge N+1.
  - rise/fall are registered and high for exactly the cycle after edge N+2.
  - edge_cnt and interval update at that same edge.
- On an edge_det cycle with en=1 and clear=0:
  - rise <= sync2 & ~prev; fall <= ~sync2 & prev.
  - edge_cnt <= edge_cnt+1 (wraps).
  - If first_seen=1: interval <= min(gap_cnt+1, 2^INT_W-1) and interval_vld <= 1. Otherwise interval is unchanged and interval_vld <= 0.
  - first_seen <= 1; gap_cnt <= 0; stall <= 0.
- Non-edge cycle with en=1: gap_cnt <= gap_cnt+1, saturating at 2^INT_W-1. stall <= 1 when gap_cnt+1 >= TIMEOUT.
- Interval definition: edges P cycles apart report interval=P.
- en=0:
  - rise, fall and interval_vld are forced to 0.
  - All counters and stall hold.
  - Edges occurring while disabled are lost; prev still tracks the input.
- clear=1 (priority over edge and en):
  - edge_cnt, gap_cnt, interval, stall, rise, fall and interval_vld go to 0; first_seen goes to 0.
  - The synchronizer is not cleared, so no spurious edge follows.
- Reset release with data_in=1: the resulting 0->1 is a genuine first edge. It is counted and rise pulses, with interval_vld=0.
- Saturation: gap_cnt stops at all-ones and never wraps. stall stays asserted until the next counted edge, clear, or reset.
- Simultaneous rise and fall are impossible; each edge_det cycle produces exactly one of them.

Test Plan:
- Reset and first edge: hold reset=0 while toggling data_in → all outputs 0. Release, then drive data_in 0→1 sampled at edge N → q_sync=1 after N+1; rise=1 for one cycle after N+2; edge_cnt=1; interval_vld=0.
- Periodic toggling: data_in toggles every 10 cycles for 6 edges, en=1 → alternating rise/fall pulses; edge_cnt=6; interval=10 with interval_vld on edges 2–6 (5 pulses); stall=0 throughout.
- Stall and saturation: after an edge, hold data_in for 300 cycles → stall=1 starting 32 cycles after the edge pulse. On the next toggle: stall=0, interval=255 (saturated), interval_vld=1.
- Counter wrap: 256 edges at period 4 → edge_cnt returns to 0x00; interval=4.
- clear and en interaction:
  - clear asserted in the same cycle as an edge_det → edge_cnt=0, rise/fall=0, no interval_vld.
  - The next edge counts as the first: edge_cnt=1, interval_vld=0.
  - en=0 across 3 toggles → no pulses; edge_cnt unchanged.
- Async reset mid-operation: drop reset between clock edges while stall=1 and edge_cnt=0x2A → all outputs 0 before the next clk edge. After release, behaviour matches the first scenario.
